// File: rtl/key_edit_ctrl_pkg.sv
// Shared constants and types for the front-panel key/edit controller.
package tube_pkg;
    localparam int NUM_KEYS   = 4;
    localparam int NUM_DIGITS = 8;
    localparam int GROUP_W    = 8;

    localparam int KEY_DEC  = 3;
    localparam int KEY_INC  = 2;
    localparam int KEY_MODE = 1;
    localparam int KEY_LOAD = 0;

    typedef logic [1:0] group_t;
endpackage

// File: rtl/key_edit_ctrl_if.sv
// Panel bus: raw keys and switch byte in, display value and edit status out.
interface key_edit_ctrl_if;
    import tube_pkg::*;

    logic [NUM_KEYS-1:0]   Key;
    logic [GROUP_W-1:0]    Sw;
    logic [31:0]           value;
    logic                  edit_mode;
    group_t                edit_group;
    logic [NUM_DIGITS-1:0] blank_mask;

    modport master (
        output Key, Sw,
        input  value, edit_mode, edit_group, blank_mask
    );

    modport slave (
        input  Key, Sw,
        output value, edit_mode, edit_group, blank_mask
    );
endinterface

// File: rtl/key_edit_ctrl_debounce.sv
// Per-key 2-flop synchroniser, stability counter and registered press pulse.
module key_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);
    logic                     sync_1;
    logic                     sync_2;
    logic                     state;
    logic [DEBOUNCE_BITS-1:0] cnt;

    // Sync flops reset to the released level so that reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            state  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == state) begin
                cnt <= '0;
            end else if (&cnt) begin
                state <= sync_2;
                cnt   <= '0;
                press <= state & ~sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/key_edit_ctrl.sv
// Front-panel edit stage: key arbitration, edit registers and blink mask for the digit scanner.
// Optional build macro LIVE_PREVIEW_EN shows the switch byte in the selected group while editing.
module key_edit_ctrl
    import tube_pkg::*;
#(
    parameter int          DEBOUNCE_BITS = 16,
    parameter int          BLINK_BIT     = 22,
    parameter logic [31:0] INIT_VALUE    = 32'h0A1B2C3D
) (
    input  logic            clk,
    input  logic            rst_n,
    key_edit_ctrl_if.slave  bus
);
    logic [NUM_KEYS-1:0]   press;
    logic [31:0]           stored;
    logic [31:0]           stored_nxt;
    logic                  mode;
    logic                  mode_nxt;
    group_t                group;
    group_t                group_nxt;
    logic [BLINK_BIT:0]    blink_cnt;
    logic [NUM_DIGITS-1:0] blank_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_BITS(DEBOUNCE_BITS)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_raw(bus.Key[k]),
            .press  (press[k])
        );
    end

    // Highest-priority pulse wins; a blocked higher-priority pulse still masks lower ones.
    always_comb begin
        stored_nxt = stored;
        mode_nxt   = mode;
        group_nxt  = group;
        if (press[KEY_DEC]) begin
            if (mode) group_nxt = group - 2'd1;
        end else if (press[KEY_INC]) begin
            if (mode) group_nxt = group + 2'd1;
        end else if (press[KEY_MODE]) begin
            mode_nxt = ~mode;
        end else if (press[KEY_LOAD]) begin
            if (mode) stored_nxt[GROUP_W*group +: GROUP_W] = bus.Sw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored    <= INIT_VALUE;
            mode      <= 1'b0;
            group     <= '0;
            blink_cnt <= '0;
            blank_q   <= '0;
        end else begin
            stored    <= stored_nxt;
            mode      <= mode_nxt;
            group     <= group_nxt;
            blink_cnt <= blink_cnt + 1'b1;
            blank_q   <= (mode && blink_cnt[BLINK_BIT])
                         ? NUM_DIGITS'(8'b11 << {group, 1'b0}) : '0;
        end
    end

`ifdef LIVE_PREVIEW_EN
    logic [31:0] value_q;
    logic [31:0] value_nxt;

    always_comb begin
        value_nxt = stored_nxt;
        if (mode_nxt) value_nxt[GROUP_W*group_nxt +: GROUP_W] = bus.Sw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= INIT_VALUE;
        else        value_q <= value_nxt;
    end

    assign bus.value = value_q;
`else
    assign bus.value = stored;
`endif

    assign bus.edit_mode  = mode;
    assign bus.edit_group = group;
    assign bus.blank_mask = blank_q;
endmodule

// File: tb/tb_key_edit_ctrl.sv
// Directed self-checking bench for key_edit_ctrl with short debounce and blink periods.
module tb_key_edit_ctrl;
    import tube_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc;

    key_edit_ctrl_if bus ();

    key_edit_ctrl #(
        .DEBOUNCE_BITS(4),
        .BLINK_BIT    (5),
        .INIT_VALUE   (32'h0A1B2C3D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Posedges seen since reset release; drives the expected blink phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int k);
        bus.Key[k] = 1'b0;
        idle(30);
        bus.Key[k] = 1'b1;
        idle(30);
    endtask

    task automatic check_idle_state(input string tag, input logic [31:0] v, input logic m, input logic [1:0] g);
        check({tag, "_value"}, bus.value, v);
        check({tag, "_mode"},  {31'd0, bus.edit_mode}, {31'd0, m});
        check({tag, "_group"}, {30'd0, bus.edit_group}, {30'd0, g});
    endtask

    initial begin
        bus.Key = 4'hF;
        bus.Sw  = 8'h00;

        // Reset state
        idle(3);
        check_idle_state("reset", 32'h0A1B2C3D, 1'b0, 2'd0);
        check("reset_blank", {24'd0, bus.blank_mask}, 32'h0);
        rst_n = 1'b1;
        idle(100);
        check_idle_state("idle", 32'h0A1B2C3D, 1'b0, 2'd0);
        check("idle_blank", {24'd0, bus.blank_mask}, 32'h0);

        // Short glitch is ignored
        bus.Key[KEY_MODE] = 1'b0;
        idle(10);
        bus.Key[KEY_MODE] = 1'b1;
        idle(40);
        check("glitch10_mode", {31'd0, bus.edit_mode}, 32'd0);

        // Exact press latency
        bus.Key[KEY_MODE] = 1'b0;
        idle(18);
        check("lat18_mode", {31'd0, bus.edit_mode}, 32'd0);
        idle(1);
        check("lat19_mode", {31'd0, bus.edit_mode}, 32'd1);
        idle(11);
        bus.Key[KEY_MODE] = 1'b1;
        idle(40);
        check("release_mode", {31'd0, bus.edit_mode}, 32'd1);

        // Group stepping with wrap
        press_key(KEY_DEC);
        check("dec_wrap", {30'd0, bus.edit_group}, 32'd3);
        press_key(KEY_INC);
        check("inc_wrap", {30'd0, bus.edit_group}, 32'd0);
        press_key(KEY_INC);
        press_key(KEY_INC);
        check("inc_x2", {30'd0, bus.edit_group}, 32'd2);
        press_key(KEY_MODE);
        check("exit_mode", {31'd0, bus.edit_mode}, 32'd0);
        press_key(KEY_INC);
        check("inc_no_edit", {30'd0, bus.edit_group}, 32'd2);
        press_key(KEY_MODE);
        check_idle_state("reenter", 32'h0A1B2C3D, 1'b1, 2'd2);
        press_key(KEY_DEC);
        check("dec_to_1", {30'd0, bus.edit_group}, 32'd1);

        // Byte load
        bus.Sw = 8'h5A;
        press_key(KEY_LOAD);
        check("load_5a", bus.value, 32'h0A1B5A3D);
        press_key(KEY_MODE);
        bus.Sw = 8'hFF;
        press_key(KEY_LOAD);
        check_idle_state("load_no_edit", 32'h0A1B5A3D, 1'b0, 2'd1);
`ifdef LIVE_PREVIEW_EN
        press_key(KEY_MODE);
        bus.Sw = 8'h77;
        idle(2);
        check("preview_77", bus.value, 32'h0A1B773D);
        press_key(KEY_MODE);
        check("preview_restore", bus.value, 32'h0A1B5A3D);
`endif

        // Blink mask tracks the free-running phase
        press_key(KEY_MODE);
        press_key(KEY_INC);
        check_idle_state("blink_setup", 32'h0A1B5A3D, 1'b1, 2'd2);
        for (int i = 0; i < 96; i++) begin
            check("blink_on", {24'd0, bus.blank_mask},
                  (((cyc - 1) >> 5) & 1) != 0 ? 32'h30 : 32'h0);
            idle(1);
        end
        press_key(KEY_MODE);
        for (int i = 0; i < 70; i++) begin
            check("blink_off", {24'd0, bus.blank_mask}, 32'h0);
            idle(1);
        end

        // Simultaneous inc/dec: decrement wins
        press_key(KEY_MODE);
        bus.Key[KEY_DEC] = 1'b0;
        bus.Key[KEY_INC] = 1'b0;
        idle(30);
        bus.Key = 4'hF;
        idle(30);
        check_idle_state("dec_over_inc", 32'h0A1B5A3D, 1'b1, 2'd1);

        // Reset in the middle of a debounce
        bus.Key[KEY_MODE] = 1'b0;
        idle(10);
        rst_n = 1'b0;
        #1;
        check_idle_state("mid_reset", 32'h0A1B2C3D, 1'b0, 2'd0);
        check("mid_reset_blank", {24'd0, bus.blank_mask}, 32'h0);
        idle(3);
        bus.Key = 4'hF;
        idle(1);
        rst_n = 1'b1;
        idle(50);
        check_idle_state("post_reset", 32'h0A1B2C3D, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
